fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch front end of the 5-stage pipeline, directly upstream of the IF/ID register.
//  Owns the PC and issues in-order requests to a variable-latency instruction memory.
//  Buffers returned instructions with their PCs in a small queue.
//  Presents {pc, insn} downstream on a valid/ready handshake; applies branch redirects from EXE.
// PARAMETERS
//  XLEN      32  address/PC width
//  ILEN      32  instruction width
//  RESET_PC  0   first fetch address after reset
//  QDEPTH    4   fetch queue entries; also the credit limit (in-flight + queued), power of 2, >=2
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     reset, asynchronous, active-high
//  redirect_valid  in   1     branch/jump taken (from branch control in EXE)
//  redirect_pc     in   XLEN  redirect target
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request
//  imem_req_addr   out  XLEN  fetch address
//  imem_rsp_valid  in   1     response valid; responses return in request order, one per cycle max
//  imem_rsp_insn   in   ILEN  returned instruction
//  if_valid        out  1     {if_pc, if_insn} valid to IF/ID
//  if_ready        in   1     IF/ID accepts (driven low by pipeline stall)
//  if_pc           out  XLEN  PC of presented instruction
//  if_insn         out  ILEN  presented instruction
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - fetch_pc=RESET_PC; queue empty; occupancy=0; drop_cnt=0.
//   - All outputs low except imem_req_addr=RESET_PC.
//  Issue:
//   - imem_req_valid = !rst && !redirect_valid && (occupancy < QDEPTH).
//   - imem_req_addr = fetch_pc.
//   - On req handshake: fetch_pc += 4 (mod 2^XLEN wrap); the PC is pushed into a tag FIFO.
//   - Handshake with no response: occupancy += 1.
//  Response (in order):
//   - drop_cnt>0: response discarded, drop_cnt -= 1, its tag popped.
//   - drop_cnt==0: {tag_pc, insn} pushed into the queue.
//   - A push never overflows; the credit rule guarantees space.
//  Output:
//   - if_valid = queue non-empty && !redirect_valid; data comes from the queue head.
//   - Pop on if_valid && if_ready; occupancy -= 1 per pop/drop.
//   - Output is stable while if_valid && !if_ready.
//  Latency:
//   - Request to RESET_PC in the first cycle after rst release.
//   - Response in cycle N gives if_valid in N+1 (queue registered, no bypass).
//  Redirect:
//   - redirect_valid in cycle R: queue flushed at the end of R; fetch_pc=redirect_pc & ~3 (bits[1:0] forced 0).
//   - drop_cnt = number of requests still awaiting response (excluding any response consumed in R).
//   - Occupancy is reduced to that drop_cnt.
//   - First request to the target is issued in R+1 if credit allows.
//  Simultaneous events:
//   - Redirect + response in R: response dropped.
//   - Redirect + if_ready in R: no pop (if_valid masked).
//   - Redirect while drop_cnt>0: add newly outstanding requests to drop_cnt.
//   - Push and pop in the same cycle: both occur, count unchanged.
//  Reset mid-operation:
//   - All state cleared immediately.
//   - Late imem responses after reset are the memory's responsibility; imem shares rst.
// STRUCTURE
//  - Types.v: XLEN/ILEN defines and the `instruction / `instructionAddrPath macros (reused, not redefined).
//  - New define for RESET_PC default in Types.v.
//  - One sub-module, fetch_fifo (WIDTH, DEPTH): sync FIFO with push/pop/flush/empty/full/count, async active-high rst.
//  - fetch_fifo is instantiated twice: in-flight tag FIFO (width XLEN) and instruction queue (width XLEN+ILEN).
//  - Occupancy counter and drop_cnt are $clog2(QDEPTH)+1 bits wide.
// TESTING
//  1 Reset, imem 1-cycle latency, if_ready=1 -> if_pc 0,4,8,12 on consecutive cycles; first if_valid 2 cycles after rst release.
//  2 if_ready=0 for 10 cycles -> exactly 4 requests issued; req_valid drops.
//    On release, PCs 0,4,8,12 then 16 in order; nothing lost or duplicated.
//  3 imem latency 3 with 2 outstanding; redirect_pc=0x100 -> both stale responses dropped.
//    Next if_pc=0x100; no if_valid in the redirect cycle.
//  4 Redirect coinciding with rsp_valid and if_ready -> response discarded, no pop.
//    Next request addr 0x100 in R+1.
//  5 redirect_pc=0xFFFF_FFFC -> fetch PCs FFFF_FFFC then 0000_0000 (wrap).
//    redirect_pc=0x103 -> fetch at 0x100.
//  6 Assert rst asynchronously mid-burst -> outputs low immediately; restart fetches RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared defaults and helpers for the instruction fetch front end.
//            Holds the default address/instruction widths, the reset PC,
//            the fetch queue depth and the counter-width helper used by the
//            fetch unit and its FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int                   XLEN_DEF     = 32;
    localparam int                   ILEN_DEF     = 32;
    localparam logic [XLEN_DEF-1:0]  RESET_PC_DEF = '0;
    localparam int                   QDEPTH_DEF   = 4;
    localparam int                   PC_STEP      = 4;

    // A counter that must hold 0..depth inclusive needs one bit more than
    // the index width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the fetch unit's redirect input, instruction-memory
//            request/response channel and IF/ID valid/ready channel.
// Ports    : master - fetch unit side (drives imem request and IF/ID data)
//            slave  - environment side (memory, branch control, IF/ID reg)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_insn;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_insn;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_insn,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_pc, if_insn
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_insn,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_pc, if_insn
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO with push/pop/flush and occupancy count.
//            Head data is read combinationally from the storage array.
// Ports    : clk, rst (async, active-high)
//            push, push_data - write one entry (ignored when full w/o pop)
//            pop             - drop the head entry (ignored when empty)
//            flush           - discard all entries, has priority
//            head, empty, full, count - status and head entry
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    input  logic                        flush,
    output logic [WIDTH-1:0]            head,
    output logic                        empty,
    output logic                        full,
    output logic [cnt_width(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero while empty after
    // reset; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Owns the PC, issues in-order
//            requests to a variable-latency instruction memory, queues the
//            returned instructions with their PCs and presents them to the
//            IF/ID register on valid/ready. Branch redirects flush the queue
//            and discard responses to requests already in flight.
// Ports    : clk - clock, rst - async active-high reset
//            bus - fetch_unit_if.master (redirect, imem req/rsp, IF/ID out)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              QDEPTH   = QDEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int CW = cnt_width(QDEPTH);

    logic [XLEN-1:0]      fetch_pc;
    logic [CW-1:0]        occupancy;
    logic [CW-1:0]        drop_cnt;

    logic                 req_fire;
    logic                 rsp;
    logic                 pop;
    logic                 drop_active;
    logic                 drop;
    logic                 push_q;

    logic [XLEN-1:0]      tag_head;
    logic [CW-1:0]        tag_count;
    logic                 tag_empty;
    logic                 tag_full;
    logic [XLEN+ILEN-1:0] q_head;
    logic [CW-1:0]        q_count;
    logic                 q_empty;
    logic                 q_full;
    logic                 unused_flags;

    // Occupancy counts in-flight plus queued entries, so any accepted
    // response is guaranteed a free queue slot.
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (occupancy < CW'(QDEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp         = bus.imem_rsp_valid;
    assign drop_active = (drop_cnt != '0);
    // A response arriving in the redirect cycle belongs to the old path.
    assign drop        = rsp && (drop_active || bus.redirect_valid);
    assign push_q      = rsp && !drop_active && !bus.redirect_valid;

    assign bus.if_valid = !q_empty && !bus.redirect_valid;
    assign pop          = bus.if_valid && bus.if_ready;
    assign bus.if_pc    = q_head[XLEN+ILEN-1:ILEN];
    assign bus.if_insn  = q_head[ILEN-1:0];

    assign unused_flags = &{1'b0, tag_empty, tag_full, q_full, q_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            occupancy <= '0;
            drop_cnt  <= '0;
        end else if (bus.redirect_valid) begin
            // Every tag still waiting (minus one consumed this cycle) is a
            // stale request whose response must be discarded. This also
            // accumulates onto any drops left from an earlier redirect.
            fetch_pc  <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt  <= tag_count - CW'(rsp);
            occupancy <= tag_count - CW'(rsp);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end
            if (rsp && drop_active) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            occupancy <= occupancy + CW'(req_fire) - CW'(pop) - CW'(drop);
        end
    end

    // PCs of requests awaiting a response, in issue order; every response
    // (kept or dropped) retires the oldest tag.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp),
        .flush     (1'b0),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (QDEPTH)
    ) u_insn_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data ({tag_head, bus.imem_rsp_insn}),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A memory model answers
//            requests in order after a programmable latency; a PC-stream
//            model predicts the sequence of {pc, insn} the IF/ID side must
//            receive, and a monitor compares every accepted output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .ILEN     (32),
        .RESET_PC (RST_PC),
        .QDEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];     // expected output PCs, oldest first
    logic [31:0] im_addr [$];   // memory model: accepted addresses
    int          im_due [$];    // memory model: earliest response cycle
    logic [31:0] req_log [$];   // accepted request addresses (directed checks)
    logic [31:0] model_pc;
    int          cyc = 0;
    int          n_req = 0;
    int          rdy_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          rst_next = 1'b1;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        im_addr.delete();
        im_due.delete();
        model_pc = RST_PC;
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample the
    // handshake that the next rising edge will commit.
    task automatic step(input bit ifr, input bit redir, input logic [31:0] tgt);
        @(negedge clk);
        rst = rst_next;
        cyc++;
        if (im_addr.size() != 0 && im_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_insn  = insn_of(im_addr.pop_front());
            void'(im_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_insn  = $urandom;
        end
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.if_ready       = ifr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        #1;
        if (!rst) begin
            if (redir) chk("req_masked_in_redirect", bus.imem_req_valid, 0);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                im_addr.push_back(bus.imem_req_addr);
                im_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
                req_log.push_back(bus.imem_req_addr);
                n_req++;
                exp_q.push_back(model_pc);
                model_pc += 32'd4;
            end
            if (redir) begin
                exp_q.delete();
                model_pc = {tgt[31:2], 2'b00};
            end
        end
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        model_reset();
        rst_next = 1'b0;
    endtask

    // Monitor: compares every accepted output against the expected stream
    // and checks that a stalled output holds steady.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_insn;
    logic [31:0] mon_e;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                chk("no_valid_in_redirect", bus.if_valid, 0);
            end else if (prev_stall) begin
                chk("stall_hold", {bus.if_valid, bus.if_pc, bus.if_insn},
                    {1'b1, prev_pc, prev_insn});
            end
            if (bus.if_valid && bus.if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got pc %h expected no output", bus.if_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_pc", bus.if_pc, mon_e);
                    chk("out_insn", bus.if_insn, insn_of(mon_e));
                end
            end
            prev_stall = bus.if_valid && !bus.if_ready;
            prev_pc    = bus.if_pc;
            prev_insn  = bus.if_insn;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  found;

        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_insn  = '0;
        bus.if_ready       = 1'b0;
        model_reset();
        #1;
        chk("reset_req_valid", bus.imem_req_valid, 0);
        chk("reset_req_addr", bus.imem_req_addr, RST_PC);
        chk("reset_if_valid", bus.if_valid, 0);
        chk("reset_if_data", {bus.if_pc, bus.if_insn}, 0);

        // 1: latency-1 memory, always ready -> 0,4,8,12 back to back
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, 0);
            if (i <= 2) chk("t1_no_valid_yet", bus.if_valid, 0);
            else        chk("t1_stream", {bus.if_valid, bus.if_pc}, {1'b1, 32'(4 * (i - 3))});
        end

        // 2: IF/ID stalled -> credit stops fetching after 4 requests
        do_reset();
        base = n_req;
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("t2_req_count", n_req - base, 4);
        chk("t2_req_valid_low", bus.imem_req_valid, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);

        // 3: latency 3, two outstanding, redirect -> both stale responses dropped
        do_reset();
        lat_lo = 3; lat_hi = 3;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 32'h100);
        chk("t3_no_valid_in_R", bus.if_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1, 0, 0);
            if (bus.if_valid) begin
                found = 1'b1;
                chk("t3_first_pc", bus.if_pc, 32'h100);
            end
        end
        chk("t3_valid_seen", found, 1);

        // 4: redirect together with a response and if_ready
        do_reset();
        lat_lo = 2; lat_hi = 2;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 32'h100);
        chk("t4_no_valid_in_R", bus.if_valid, 0);
        step(1, 0, 0);
        chk("t4_req_R1", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h100});
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // 5: PC wrap and target alignment
        do_reset();
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 32'hFFFF_FFFC);
        req_log.delete();
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("t5_wrap_a", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'hFFFF_FFFC);
        chk("t5_wrap_b", (req_log.size() > 1) ? req_log[1] : 32'hx, 32'h0000_0000);
        step(1, 1, 32'h103);
        req_log.delete();
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        chk("t5_align", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'h100);

        // 6: asynchronous reset in the middle of random traffic
        do_reset();
        rdy_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 30; i++) step(($urandom_range(3) != 0), 0, 0);
        #2;
        rst = 1'b1;
        rst_next = 1'b1;
        #1;
        chk("t6_req_valid", bus.imem_req_valid, 0);
        chk("t6_req_addr", bus.imem_req_addr, RST_PC);
        chk("t6_if_valid", bus.if_valid, 0);
        chk("t6_if_data", {bus.if_pc, bus.if_insn}, 0);
        model_reset();
        bus.imem_rsp_valid = 1'b0;
        rdy_pct = 100; lat_lo = 1; lat_hi = 1;
        step(1, 0, 0);
        step(1, 0, 0);
        rst_next = 1'b0;
        req_log.delete();
        step(1, 0, 0);
        chk("t6_restart_addr", (req_log.size() > 0) ? req_log[0] : 32'hx, RST_PC);
        for (int i = 0; i < 8; i++) step(1, 0, 0);

        // Random traffic: random stalls, memory backpressure, latency and redirects
        rdy_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(3) != 0), ($urandom_range(99) < 3),
                 ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
        end
        // Drain: memory stops accepting; everything requested must come out.
        rdy_pct = 0;
        for (int i = 0; i < 40; i++) step(1, 0, 0);
        chk("drain_exp_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
